// File: rtl/regfile_8x24_pkg.sv
// Shared definitions for the 8x24 register file: default geometry and FSM states.
// Imported by regfile_8x24 and regfile_read_mux.
package regfile_8x24_pkg;

    localparam int WIDTH_DEF = 24;
    localparam int DEPTH_DEF = 8;
    localparam int ADDR_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : regfile_8x24_pkg

// File: rtl/regfile_read_mux.sv
// Combinational DEPTH:1 selector, WIDTH bits wide.
// Instantiated once for each read port of regfile_8x24.
module regfile_read_mux
    import regfile_8x24_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] entries,
    input  logic [ADDR_W-1:0]           sel,
    output logic [WIDTH-1:0]            data
);

    assign data = entries[sel];

endmodule : regfile_read_mux

// File: rtl/regfile_8x24.sv
// 8x24 register file: two combinational read ports, one write port, r0 hardwired to zero,
// and a sequential clear FSM. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_8x24
    import regfile_8x24_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic              ClearStart,
    output logic              Busy
);

    // Only r1..r(DEPTH-1) are real storage; r0 is a constant zero at the mux input.
    logic [WIDTH-1:0]              regs [1:DEPTH-1];
    logic [DEPTH-1:0][WIDTH-1:0]   rd_vec;
    logic [WIDTH-1:0]              mux1_data;
    logic [WIDTH-1:0]              mux2_data;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] next_cnt;
    logic              wr_en;

    assign wr_en = RegWrite && (state == IDLE) && (WriteAddr != '0);
    assign Busy  = (state == CLEAR);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (ClearStart) begin
                    next_state = CLEAR;
                    next_cnt   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                next_cnt = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!ResetN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        // NOTE: this array is reset on purpose, since reset must zero every register,
        // which rules out an inferred RAM macro.
        if (!ResetN) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_en) begin
            regs[WriteAddr] <= WriteData;
        end
    end

    always_comb begin
        rd_vec[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            rd_vec[i] = regs[i];
        end
    end

    regfile_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_mux1 (
        .entries (rd_vec),
        .sel     (ReadAddr1),
        .data    (mux1_data)
    );

    regfile_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_mux2 (
        .entries (rd_vec),
        .sel     (ReadAddr2),
        .data    (mux2_data)
    );

`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes r0 and Busy, so r0 can never be forwarded.
    assign ReadData1 = (wr_en && (ReadAddr1 == WriteAddr)) ? WriteData : mux1_data;
    assign ReadData2 = (wr_en && (ReadAddr2 == WriteAddr)) ? WriteData : mux2_data;
`else
    assign ReadData1 = mux1_data;
    assign ReadData2 = mux2_data;
`endif

endmodule : regfile_8x24

// File: doc/regfile_8x24.md
REGFILE_8X24 -- requirements
Module: regfile_8x24

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the data width of each register.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the register count; the address width is log2(DEPTH) = 3.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port RegWrite, input, 1 bit: write enable.
REQ-006 The block SHALL have port WriteAddr, input, 3 bits: destination register.
REQ-007 The block SHALL have port WriteData, input, WIDTH bits: data to write.
REQ-008 The block SHALL have ports ReadAddr1 and ReadAddr2, input, 3 bits each: read-port selects.
REQ-009 The block SHALL have ports ReadData1 and ReadData2, output, WIDTH bits each: read-port data.
REQ-010 The block SHALL have port ClearStart, input, 1 bit: a pulse that starts a sequential clear of all registers.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a clear sequence is in progress.

Function
REQ-012 Reads SHALL be combinational: ReadDataN equals register[ReadAddrN] in the same cycle, with zero-cycle latency.
REQ-013 Register 0 SHALL always read 0, and writes to address 0 SHALL be discarded.
REQ-014 When RegWrite=1, Busy=0 and WriteAddr≠0, register[WriteAddr] SHALL take WriteData at the rising edge.
REQ-015 The FSM SHALL have two states, IDLE and CLEAR; its reset state is IDLE.
REQ-016 IDLE SHALL go to CLEAR on the edge where ClearStart=1; the 3-bit clear counter loads 1 on that edge.
REQ-017 In CLEAR, each edge SHALL zero register[counter] and increment the counter.
REQ-018 After the edge that clears register 7, the FSM SHALL return to IDLE; this gives 7 cycles in CLEAR and counter wrap 7->0 as the exit condition.
REQ-019 Busy SHALL equal (state == CLEAR), taken directly from a register with no combinational input path.
REQ-020 While Busy=1, RegWrite SHALL be ignored and ClearStart SHALL be ignored; there is no restart.
REQ-021 When ClearStart=1 and RegWrite=1 arrive in the same IDLE cycle, the write SHALL take effect, and the clear SHALL then erase it in a later cycle.
REQ-022 Reads during CLEAR SHALL return the current contents, both already cleared and not yet cleared.

Reset
REQ-023 ResetN=0 SHALL asynchronously zero all registers, set the FSM to IDLE, the counter to 0 and Busy to 0.
REQ-024 ResetN asserted mid-clear SHALL abort the sequence immediately.
REQ-025 Deassertion SHALL take effect at the next rising edge, with no further sequencing required.

Configuration
REQ-026 When macro REGFILE_BYPASS_EN is defined, a read SHALL return WriteData instead of the stored value if RegWrite=1, Busy=0, WriteAddr≠0 and ReadAddrN==WriteAddr.
REQ-027 When REGFILE_BYPASS_EN is not defined, reads SHALL return only stored contents; a same-cycle write becomes visible only after the edge.

Structure
REQ-028 A shared package SHALL hold WIDTH_DEF=24, DEPTH_DEF=8, ADDR_W=3 and the FSM state enum {IDLE, CLEAR}.
REQ-029 The block SHALL contain one sub-module, regfile_read_mux: an 8:1, WIDTH-wide combinational selector instantiated once per read port.
REQ-030 The FSM, counter and storage array SHALL reside in the top module.

Verification
REQ-031 Reset check: assert ResetN=0 mid-run -> all reads return 0x000000 and Busy=0 without waiting for a clock edge.
REQ-032 Write/read check: write 0xABCDEF to r5, then read r5 on both ports -> both return 0xABCDEF on the next cycle. Without the macro, same-cycle read of r5 returns the old value; with REGFILE_BYPASS_EN, same-cycle read returns 0xABCDEF.
REQ-033 Register-zero check: write 0x123456 to r0 -> read of r0 returns 0x000000.
REQ-034 Clear-sequence check: fill r1..r7 with 0xFFFFFF, then pulse ClearStart -> Busy is high for exactly 7 cycles, r1 reads 0 after the first edge and r7 reads 0 after the seventh; a write to r3 issued during Busy is dropped.
REQ-035 Mid-clear reset check: assert ResetN=0 at clear cycle 3 -> Busy=0 immediately, all registers read 0, and the next ClearStart runs a full 7-cycle sequence.
REQ-036 Simultaneous-event check: raise RegWrite to r7 with 0x00AA00 together with ClearStart -> r7 reads 0x00AA00 until the seventh clear edge, then reads 0.
